// File: rtl/and8way_bist.sv
// and8way_bist: exhaustive built-in self-test for an external 8-input AND gate.
// Walks all 256 input vectors, spending one settle cycle (DRIVE) and one
// compare cycle (SAMPLE) on each, and counts mismatches against &vec.
// The start request is registered before the FSM acts on it. A start seen at
// edge T therefore begins the run at edge T+1, the first sample lands on edge
// T+3, and done rises 513 edges after T.
// Optional build macro: AND8WAY_BIST_FAILLOG_EN adds first_fail/fail_seen,
// which record the first mismatching vector of a run.
module and8way_bist #(
    parameter int ERR_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [7:0]       dut_in,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
`ifdef AND8WAY_BIST_FAILLOG_EN
    output logic [7:0]       first_fail,
    output logic             fail_seen,
`endif
    output logic [ERR_W-1:0] err_cnt
);

    // state    | meaning
    // S_IDLE   | waiting for start, outputs hold last values
    // S_DRIVE  | dut_in = vec, gate output settling
    // S_SAMPLE | compare dut_out with &vec, advance vec or finish
    // S_DONE   | run complete, done/pass valid, start re-arms
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_start;
    logic [7:0]       r_vec;
    logic [ERR_W-1:0] r_err_cnt;
    logic [ERR_W-1:0] w_err_next;
    logic             r_pass;
    logic             w_accept;
    logic             w_sample;
    logic             w_busy;
    logic             w_done;
    logic             w_last;
    logic             w_expected;
    logic             w_mismatch;

    assign w_last     = (r_vec == 8'hFF);
    assign w_expected = &r_vec;
    // Case inequality: an X or Z coming back from the gate counts as a failure.
    assign w_mismatch = (dut_out !== w_expected);
    assign w_err_next = (w_mismatch && (r_err_cnt != ERR_MAX)) ? r_err_cnt + 1'b1 : r_err_cnt;

    // Register start only while a new run can be accepted; requests made while busy are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start <= 1'b0;
        end else begin
            r_start <= start && ((r_state == S_IDLE) || (r_state == S_DONE));
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-state control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_busy       = 1'b1;
                w_state_next = S_SAMPLE;
            end
            S_SAMPLE: begin
                w_busy       = 1'b1;
                w_sample     = 1'b1;
                w_state_next = w_last ? S_DONE : S_DRIVE;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (r_start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_DRIVE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Vector walk, saturating error count and end-of-run verdict.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vec     <= 8'h00;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_accept) begin
            r_vec     <= 8'h00;
            r_err_cnt <= '0;
            r_pass    <= 1'b0;
        end else if (w_sample) begin
            r_err_cnt <= w_err_next;
            if (w_last) begin
                r_pass <= (w_err_next == '0);
            end else begin
                r_vec <= r_vec + 8'd1;
            end
        end
    end

`ifdef AND8WAY_BIST_FAILLOG_EN
    logic [7:0] r_first_fail;
    logic       r_fail_seen;

    // Latch the vector of the first mismatch in a run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_first_fail <= 8'h00;
            r_fail_seen  <= 1'b0;
        end else if (w_accept) begin
            r_first_fail <= 8'h00;
            r_fail_seen  <= 1'b0;
        end else if (w_sample && w_mismatch && !r_fail_seen) begin
            r_first_fail <= r_vec;
            r_fail_seen  <= 1'b1;
        end
    end

    assign first_fail = r_first_fail;
    assign fail_seen  = r_fail_seen;
`endif

    assign dut_in  = r_vec;
    assign busy    = w_busy;
    assign done    = w_done;
    assign pass    = r_pass;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_and8way_bist.sv
`timescale 1ns/1ps
module tb_and8way_bist;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       start4;
    logic [7:0] dut_in;
    logic [7:0] dut_in4;
    logic       dut_out;
    logic       dut_out4;
    logic       busy, done, pass;
    logic       busy4, done4, pass4;
    logic [8:0] err_cnt;
    logic [3:0] err_cnt4;
`ifdef AND8WAY_BIST_FAILLOG_EN
    logic [7:0] first_fail, first_fail4;
    logic       fail_seen, fail_seen4;
`endif

    int gate_mode;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         err;
        logic       pass;
        logic [7:0] ff;
        logic       seen;
        int         cycles;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    // 0: good AND, 1: stuck-at-0, 2: stuck-at-1, 3: OR gate
    function automatic logic gate_fn(input int mode, input logic [7:0] v);
        case (mode)
            0:       return &v;
            1:       return 1'b0;
            2:       return 1'b1;
            default: return |v;
        endcase
    endfunction

    assign dut_out  = gate_fn(gate_mode, dut_in);
    assign dut_out4 = 1'b1;

    and8way_bist #(.ERR_W(9)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dut_in     (dut_in),
        .dut_out    (dut_out),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
`ifdef AND8WAY_BIST_FAILLOG_EN
        .first_fail (first_fail),
        .fail_seen  (fail_seen),
`endif
        .err_cnt    (err_cnt)
    );

    and8way_bist #(.ERR_W(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .dut_in     (dut_in4),
        .dut_out    (dut_out4),
        .busy       (busy4),
        .done       (done4),
        .pass       (pass4),
`ifdef AND8WAY_BIST_FAILLOG_EN
        .first_fail (first_fail4),
        .fail_seen  (fail_seen4),
`endif
        .err_cnt    (err_cnt4)
    );

    // Reference: the only vector whose AND is 1 is 8'hFF.
    function automatic exp_t model_run(input int mode, input int err_max);
        exp_t       e;
        logic [7:0] vv;
        e.err = 0; e.pass = 1'b0; e.ff = 8'h00; e.seen = 1'b0; e.cycles = 513;
        for (int v = 0; v < 256; v++) begin
            vv = v[7:0];
            if (gate_fn(mode, vv) !== (vv == 8'hFF)) begin
                if (!e.seen) begin
                    e.ff   = vv;
                    e.seen = 1'b1;
                end
                if (e.err < err_max) e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    task automatic run_bist(input int mode, input int pulse_at, input string name);
        exp_t e;
        int   cycles;
        logic pass_hold;
        gate_mode = mode;
        sb_q.push_back(model_run(mode, 511));
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_accept_edge: got %b expected 0", name, busy);
        end
        cycles = 0;
        while (1) begin
            @(posedge clk); #1;
            cycles++;
            start = (cycles == pulse_at);
            if (cycles == 1) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_done_after_start: got busy=%b done=%b expected busy=1 done=0", name, busy, done);
                end
            end
            if (done === 1'b1 && cycles > 1) break;
            if (cycles > 700) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s done_timeout: got no done after %0d cycles expected 513", name, cycles);
                break;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        n_checks++;
        if (cycles !== e.cycles) begin
            n_fail++;
            $display("FAIL %s run_length: got %0d expected %0d", name, cycles, e.cycles);
        end
        n_checks++;
        if (int'(err_cnt) !== e.err) begin
            n_fail++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, e.err);
        end
        n_checks++;
        if (pass !== e.pass) begin
            n_fail++;
            $display("FAIL %s pass: got %b expected %b", name, pass, e.pass);
        end
        n_checks++;
        if (busy !== 1'b0 || dut_in !== 8'hFF) begin
            n_fail++;
            $display("FAIL %s end_state: got busy=%b dut_in=%h expected busy=0 dut_in=ff", name, busy, dut_in);
        end
`ifdef AND8WAY_BIST_FAILLOG_EN
        n_checks++;
        if (first_fail !== e.ff || fail_seen !== e.seen) begin
            n_fail++;
            $display("FAIL %s faillog: got %h/%b expected %h/%b", name, first_fail, fail_seen, e.ff, e.seen);
        end
`endif
        pass_hold = pass;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b1 || pass !== pass_hold || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_hold: got done=%b pass=%b busy=%b expected done=1 pass=%b busy=0", name, done, pass, busy, pass_hold);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (dut_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_values: got dut_in=%h busy=%b done=%b pass=%b err=%0d expected all zero", dut_in, busy, done, pass, err_cnt);
        end
        n_checks++;
        if (dut_in4 !== 8'h00 || busy4 !== 1'b0 || done4 !== 1'b0 || pass4 !== 1'b0 || err_cnt4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_values_w4: got dut_in=%h busy=%b done=%b pass=%b err=%0d expected all zero", dut_in4, busy4, done4, pass4, err_cnt4);
        end
`ifdef AND8WAY_BIST_FAILLOG_EN
        n_checks++;
        if (first_fail !== 8'h00 || fail_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_faillog: got %h/%b expected 00/0", first_fail, fail_seen);
        end
`endif
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_without_start: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_good_gate();
        run_bist(0, 0, "good_gate");
    endtask

    task automatic test_stuck_at0();
        run_bist(1, 0, "stuck_at0");
    endtask

    task automatic test_stuck_at1();
        run_bist(2, 0, "stuck_at1");
    endtask

    task automatic test_or_gate();
        run_bist(3, 0, "or_gate");
    endtask

    task automatic test_back_to_back();
        run_bist(0, 0, "back_to_back_1");
        run_bist(0, 0, "back_to_back_2");
    endtask

    task automatic test_start_during_run();
        run_bist(0, 50, "start_during_run");
    endtask

    task automatic test_reset_midrun();
        int cycles;
        gate_mode = 2;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cycles = 0;
        repeat (100) begin
            @(posedge clk);
            cycles++;
        end
        #1;
        n_checks++;
        if (busy !== 1'b1 || err_cnt === 9'd0) begin
            n_fail++;
            $display("FAIL midrun_active: got busy=%b err=%0d expected busy=1 err>0", busy, err_cnt);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (dut_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 9'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got dut_in=%h busy=%b done=%b pass=%b err=%0d expected all zero", dut_in, busy, done, pass, err_cnt);
        end
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_stays_idle: got busy=%b done=%b expected 0/0", busy, done);
        end
    endtask

    task automatic test_err_saturation();
        exp_t e;
        int   cycles;
        e = model_run(2, 15);
        sb_q.push_back(e);
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        cycles = 0;
        while (1) begin
            @(posedge clk); #1;
            cycles++;
            if (done4 === 1'b1) break;
            if (cycles > 700) begin
                n_checks++;
                n_fail++;
                $display("FAIL err_sat done_timeout: got no done after %0d cycles expected 513", cycles);
                break;
            end
        end
        e = sb_q.pop_front();
        n_checks++;
        if (cycles !== e.cycles) begin
            n_fail++;
            $display("FAIL err_sat run_length: got %0d expected %0d", cycles, e.cycles);
        end
        n_checks++;
        if (int'(err_cnt4) !== e.err || pass4 !== 1'b0) begin
            n_fail++;
            $display("FAIL err_sat: got err=%0d pass=%b expected err=%0d pass=0", err_cnt4, pass4, e.err);
        end
`ifdef AND8WAY_BIST_FAILLOG_EN
        n_checks++;
        if (first_fail4 !== e.ff || fail_seen4 !== e.seen) begin
            n_fail++;
            $display("FAIL err_sat faillog: got %h/%b expected %h/%b", first_fail4, fail_seen4, e.ff, e.seen);
        end
`endif
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start4    = 1'b0;
        gate_mode = 0;
        test_reset();
        test_good_gate();
        test_stuck_at0();
        test_stuck_at1();
        test_or_gate();
        test_back_to_back();
        test_start_during_run();
        test_reset_midrun();
        test_err_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
